// File: rtl/integral_image_gen.sv
// Integral image generator: turns a raster stream of pixels into its summed-area image.
// Each output word carries II(x,y) and the linear tile address y*width + x.
// The optional macro II_SQSUM_EN adds out_sqdata, the integral of pix^2, used for
// window variance normalisation downstream.
module integral_image_gen #(
    parameter int unsigned MAX_WIDTH = 1024,
    parameter int unsigned PIX_W     = 8,
    parameter int unsigned SUM_W     = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [15:0]             cfg_width,
    input  logic [15:0]             cfg_height,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    cfg_err,
    input  logic                    pix_valid,
    output logic                    pix_ready,
    input  logic [PIX_W-1:0]        pix_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SUM_W-1:0]        out_data,
`ifdef II_SQSUM_EN
    output logic [SUM_W+PIX_W-1:0]  out_sqdata,
`endif
    output logic [31:0]             out_addr
);

    localparam int unsigned AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e            state_q, state_d;
    logic [15:0]       width_q, width_d;
    logic [15:0]       height_q, height_d;
    logic [15:0]       x_q, x_d;
    logic [15:0]       y_q, y_d;
    logic [31:0]       addr_q, addr_d;
    logic [SUM_W-1:0]  row_sum_q, row_sum_d;
    logic              out_valid_q, out_valid_d;
    logic [SUM_W-1:0]  out_data_q, out_data_d;
    logic [31:0]       out_addr_q, out_addr_d;
    logic              done_q, done_d;
    logic              cfg_err_q, cfg_err_d;

    // Line buffer: entry x holds II(x, y-1); never reset, row 0 reads are forced to zero.
    logic [SUM_W-1:0]  linebuf [MAX_WIDTH];

    logic              cfg_ok;
    logic              accept;
    logic              out_take;
    logic              last_col;
    logic              last_row;
    logic [AW-1:0]     lb_idx;
    logic [SUM_W-1:0]  pix_ext;
    logic [SUM_W-1:0]  row_sum_nxt;
    logic [SUM_W-1:0]  above;
    logic [SUM_W-1:0]  ii_val;

    assign lb_idx   = x_q[AW-1:0];
    assign cfg_ok   = (cfg_width != 16'd0) && (32'(cfg_width) <= MAX_WIDTH) &&
                      (cfg_height != 16'd0);
    assign pix_ready = (state_q == StRun) && (!out_valid_q || out_ready);
    assign accept   = pix_valid && pix_ready;
    assign out_take = out_valid_q && out_ready;
    assign last_col = (x_q == width_q - 16'd1);
    assign last_row = (y_q == height_q - 16'd1);

    // Datapath: running row sum plus the integral of the row above.
    always_comb begin
        pix_ext     = {{(SUM_W-PIX_W){1'b0}}, pix_data};
        row_sum_nxt = ((x_q == 16'd0) ? '0 : row_sum_q) + pix_ext;
        above       = (y_q == 16'd0) ? '0 : linebuf[lb_idx];
        ii_val      = row_sum_nxt + above;
    end

    // Next-state logic for the control FSM, counters and output register.
    always_comb begin
        state_d     = state_q;
        width_d     = width_q;
        height_d    = height_q;
        x_d         = x_q;
        y_d         = y_q;
        addr_d      = addr_q;
        row_sum_d   = row_sum_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        done_d      = 1'b0;
        cfg_err_d   = cfg_err_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (cfg_ok) begin
                        width_d   = cfg_width;
                        height_d  = cfg_height;
                        x_d       = 16'd0;
                        y_d       = 16'd0;
                        addr_d    = 32'd0;
                        row_sum_d = '0;
                        cfg_err_d = 1'b0;
                        state_d   = StRun;
                    end else begin
                        cfg_err_d = 1'b1;
                        done_d    = 1'b1;
                    end
                end
            end
            StRun: begin
                if (accept) begin
                    row_sum_d = row_sum_nxt;
                    addr_d    = addr_q + 32'd1;
                    if (last_col) begin
                        x_d = 16'd0;
                        y_d = y_q + 16'd1;
                        if (last_row) begin
                            state_d = StDrain;
                        end
                    end else begin
                        x_d = x_q + 16'd1;
                    end
                end
            end
            StDrain: begin
                // The final word sits in the output register; finish once it leaves.
                if (out_take) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A new pixel reloads the register even if the old word hands off this cycle.
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = ii_val;
            out_addr_d  = addr_q;
        end else if (out_take) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            width_q     <= 16'd0;
            height_q    <= 16'd0;
            x_q         <= 16'd0;
            y_q         <= 16'd0;
            addr_q      <= 32'd0;
            row_sum_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= 32'd0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            width_q     <= width_d;
            height_q    <= height_d;
            x_q         <= x_d;
            y_q         <= y_d;
            addr_q      <= addr_d;
            row_sum_q   <= row_sum_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    // Line buffer write-back of the freshly computed integral.
    always_ff @(posedge clk) begin
        if (accept) begin
            linebuf[lb_idx] <= ii_val;
        end
    end

`ifdef II_SQSUM_EN
    localparam int unsigned SQ_W = SUM_W + PIX_W;

    logic [SQ_W-1:0]      sq_linebuf [MAX_WIDTH];
    logic [SQ_W-1:0]      row_sq_q;
    logic [SQ_W-1:0]      out_sq_q;
    logic [2*PIX_W-1:0]   pix_sq;
    logic [SQ_W-1:0]      row_sq_nxt;
    logic [SQ_W-1:0]      sq_val;

    // Squared-pixel datapath mirroring the plain integral.
    always_comb begin
        pix_sq     = {{PIX_W{1'b0}}, pix_data} * {{PIX_W{1'b0}}, pix_data};
        row_sq_nxt = ((x_q == 16'd0) ? '0 : row_sq_q) + {{(SQ_W-2*PIX_W){1'b0}}, pix_sq};
        sq_val     = row_sq_nxt + ((y_q == 16'd0) ? '0 : sq_linebuf[lb_idx]);
    end

    // Square accumulator and output word, updated with the same handshake as out_data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_sq_q <= '0;
            out_sq_q <= '0;
        end else if (state_q == StIdle && start && cfg_ok) begin
            row_sq_q <= '0;
        end else if (accept) begin
            row_sq_q <= row_sq_nxt;
            out_sq_q <= sq_val;
        end
    end

    // Square line buffer write-back.
    always_ff @(posedge clk) begin
        if (accept) begin
            sq_linebuf[lb_idx] <= sq_val;
        end
    end

    assign out_sqdata = out_sq_q;
`endif

    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign cfg_err   = cfg_err_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;

endmodule

// File: tb/tb_integral_image_gen.sv
// Directed bench for integral_image_gen with a scoreboard of expected output words.
module tb_integral_image_gen;

    localparam int unsigned MAX_WIDTH = 1024;
    localparam int unsigned PIX_W     = 8;
    localparam int unsigned SUM_W     = 32;

    logic                clk = 1'b0;
    logic                reset;
    logic [15:0]         cfg_width;
    logic [15:0]         cfg_height;
    logic                start;
    logic                busy;
    logic                done;
    logic                cfg_err;
    logic                pix_valid;
    logic                pix_ready;
    logic [PIX_W-1:0]    pix_data;
    logic                out_valid;
    logic                out_ready;
    logic [SUM_W-1:0]    out_data;
    logic [31:0]         out_addr;
`ifdef II_SQSUM_EN
    logic [SUM_W+PIX_W-1:0] out_sqdata;
`endif

    integral_image_gen #(
        .MAX_WIDTH (MAX_WIDTH),
        .PIX_W     (PIX_W),
        .SUM_W     (SUM_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
`ifdef II_SQSUM_EN
        .out_sqdata (out_sqdata),
`endif
        .out_addr   (out_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [63:0] sq;
        logic [31:0] addr;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          last_hs = -100;
    logic [7:0]  img [0:63];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic [31:0] prev_addr;
    bit          tog_stop;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Output monitor: stability while stalled, scoreboard pop on handshake.
    always @(negedge clk) begin
        if (reset && out_valid) begin
            if (prev_stall) begin
                check("stall_data", 64'(out_data), 64'(prev_data));
                check("stall_addr", 64'(out_addr), 64'(prev_addr));
            end
            if (out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 64'(sb.size()), 64'd1);
                end else begin
                    e = sb.pop_front();
                    check("out_data", 64'(out_data), e.data);
                    check("out_addr", 64'(out_addr), 64'(e.addr));
`ifdef II_SQSUM_EN
                    check("out_sqdata", 64'(out_sqdata), e.sq);
`endif
                end
                last_hs = cyc;
            end
            prev_stall = !out_ready;
            prev_data  = out_data;
            prev_addr  = out_addr;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 64; i++) img[i] = v;
    endtask

    task automatic push_exp(input int w, input int x, input int y);
        logic [63:0] s;
        logic [63:0] q;
        s = 0;
        q = 0;
        for (int j = 0; j <= y; j++) begin
            for (int i = 0; i <= x; i++) begin
                s += 64'(img[j*w+i]);
                q += 64'(img[j*w+i]) * 64'(img[j*w+i]);
            end
        end
        sb.push_back('{data: s, sq: q, addr: 32'(y*w + x)});
    endtask

    // Called at posedge+1; returns at posedge+1 after the start edge.
    task automatic do_start(input int w, input int h);
        cfg_width  = 16'(w);
        cfg_height = 16'(h);
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_pix(input logic [7:0] p);
        bit ok;
        ok        = 1'b0;
        pix_valid = 1'b1;
        pix_data  = p;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (pix_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        pix_valid = 1'b0;
        check("pix_accepted", 64'(ok), 64'd1);
    endtask

    task automatic send_range(input int w, input int k0, input int k1);
        for (int k = k0; k <= k1; k++) begin
            push_exp(w, k % w, k / w);
            send_pix(img[k]);
        end
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        int dc;
        logic b;
        seen = 1'b0;
        dc   = 0;
        b    = 1'b1;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                dc   = cyc;
                b    = busy;
            end
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        check({tag, "_done_latency"}, 64'(dc - last_hs), 64'd1);
        check({tag, "_busy_at_done"}, 64'(b), 64'd0);
        @(negedge clk);
        check({tag, "_done_pulse_len"}, 64'(done), 64'd0);
        check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        pix_valid  = 1'b0;
        pix_data   = '0;
        out_ready  = 1'b1;
        cfg_width  = 16'd0;
        cfg_height = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_cfg_err", 64'(cfg_err), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_addr", 64'(out_addr), 64'd0);
        check("rst_pix_ready", 64'(pix_ready), 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // 3x3 all ones, free-flowing output.
        fill(8'd1);
        do_start(3, 3);
        check("t1_busy", 64'(busy), 64'd1);
        send_range(3, 0, 8);
        wait_done("t1");

        // 2x2 of 255.
        fill(8'd255);
        do_start(2, 2);
        send_range(2, 0, 3);
        wait_done("t2");

        // 4x2 ramp with out_ready toggled 1,0,0,1,...
        for (int i = 0; i < 8; i++) img[i] = 8'(i + 1);
        do_start(4, 2);
        tog_stop = 1'b0;
        fork
            begin
                send_range(4, 0, 7);
                tog_stop = 1'b1;
            end
            begin
                for (int i = 0; i < 500 && !tog_stop; i++) begin
                    out_ready = (i % 3 == 0);
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_ready = 1'b1;
        wait_done("t3");

        // Pixels offered while idle are not accepted.
        pix_valid = 1'b1;
        pix_data  = 8'd7;
        @(negedge clk);
        check("idle_pix_ready", 64'(pix_ready), 64'd0);
        @(posedge clk);
        #1;
        check("idle_no_output", 64'(out_valid), 64'd0);
        pix_valid = 1'b0;

        // Illegal configurations.
        do_start(0, 3);
        check("w0_cfg_err", 64'(cfg_err), 64'd1);
        check("w0_done", 64'(done), 64'd1);
        check("w0_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        check("w0_done_clear", 64'(done), 64'd0);
        check("w0_busy_after", 64'(busy), 64'd0);
        check("w0_err_sticky", 64'(cfg_err), 64'd1);
        do_start(MAX_WIDTH + 1, 2);
        check("wmax_cfg_err", 64'(cfg_err), 64'd1);
        check("wmax_done", 64'(done), 64'd1);
        check("wmax_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;

        // Legal start clears cfg_err; reset after 5 of 9 pixels.
        fill(8'd1);
        do_start(3, 3);
        check("legal_cfg_err_clear", 64'(cfg_err), 64'd0);
        check("legal_busy", 64'(busy), 64'd1);
        send_range(3, 0, 4);
        reset = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_data", 64'(out_data), 64'd0);
        check("midrst_out_addr", 64'(out_addr), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Fresh 3x3 of twos: no stale line-buffer contribution.
        fill(8'd2);
        do_start(3, 3);
        send_range(3, 0, 8);
        wait_done("t5");

        // start pulsed mid-frame with different cfg is ignored.
        for (int i = 0; i < 6; i++) img[i] = 8'(10 * i + 3);
        do_start(3, 2);
        send_range(3, 0, 2);
        do_start(2, 2);
        check("restart_busy", 64'(busy), 64'd1);
        send_range(3, 3, 5);
        wait_done("t6");

        check("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
